vga_capture: RTL and testbench

VGA_CAPTURE -- requirements
Module: vga_capture

---
 rtl/vga_pkg.sv | 25 ++
 rtl/vga_cap_fifo.sv | 56 +++++
 rtl/vga_capture.sv | 175 +++++++++++++++++
 tb/tb_vga_capture.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared VGA timing defaults, capture FSM encoding and pixel layout for the capture path
// and the display driver.
package vga_pkg;

    localparam int H_SYNC_PULSE_DEF = 96;
    localparam int HDE_START_DEF    = 144;
    localparam int H_ACTIVE_DEF     = 640;
    localparam int VDE_START_DEF    = 35;
    localparam int V_ACTIVE_DEF     = 480;
    localparam int CAP_FIFO_DEPTH_DEF = 4;

    typedef enum logic [1:0] {
        WAIT_INIT  = 2'd0,
        WAIT_VSYNC = 2'd1,
        CAPTURE    = 2'd2,
        DROP       = 2'd3
    } cap_state_t;

    typedef struct packed {
        logic [4:0] r;
        logic [5:0] g;
        logic [4:0] b;
    } rgb565_t;

endpackage

// File: rtl/vga_cap_fifo.sv
// Synchronous show-ahead word FIFO with a registered head; a pop and a push in the same
// cycle are both taken, so a full FIFO can accept a word while it is being drained.
module vga_cap_fifo
    import vga_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = CAP_FIFO_DEPTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr, rd_ptr_nxt;
    logic [AW:0]      count, count_nxt;
    logic             do_push, do_pop, bypass;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_comb begin
        rd_ptr_nxt = rd_ptr + AW'(do_pop);
        count_nxt  = count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        // the incoming word becomes the head only when nothing else is left
        bypass     = do_push && (wr_ptr == rd_ptr_nxt);
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            dout   <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(do_push);
            rd_ptr <= rd_ptr_nxt;
            count  <= count_nxt;
            if (count_nxt != '0) dout <= bypass ? din : mem[rd_ptr_nxt];
        end
    end

endmodule

// File: rtl/vga_capture.sv
// Captures RGB565 video into 32-bit pixel pairs: pin to ddr_wren is 3 cycles; a full FIFO
// drops the word and skips the rest of the frame. Stats counters need VGA_CAP_STATS_EN.
module vga_capture
    import vga_pkg::*;
#(
    parameter int H_SYNC_PULSE = H_SYNC_PULSE_DEF,
    parameter int HDE_START    = HDE_START_DEF,
    parameter int H_ACTIVE     = H_ACTIVE_DEF,
    parameter int VDE_START    = VDE_START_DEF,
    parameter int V_ACTIVE     = V_ACTIVE_DEF,
    parameter int FIFO_DEPTH   = CAP_FIFO_DEPTH_DEF
) (
    input  logic        vga_clk,
    input  logic        rst,
    input  logic        ddr_init_done,
    input  logic        vga_hsync,
    input  logic        vga_vsync,
    input  logic [4:0]  vga_r,
    input  logic [5:0]  vga_g,
    input  logic [4:0]  vga_b,
    output logic [31:0] ddr_wr_data,
    output logic        ddr_wren,
    input  logic        ddr_wr_ready,
    output logic        vga_frame_sync,
    output logic        cap_overflow,
    output logic [15:0] frame_cnt,
    output logic [15:0] drop_cnt
);

    localparam logic [10:0] H_LO     = 11'(HDE_START);
    localparam logic [10:0] H_HI     = 11'(HDE_START + H_ACTIVE);
    localparam logic [9:0]  V_LO     = 10'(VDE_START);
    localparam logic [9:0]  V_HI     = 10'(VDE_START + V_ACTIVE);
    localparam logic [10:0] H_SYNC_W = 11'(H_SYNC_PULSE);

    logic       hs_q, hs_q2, vs_q, vs_q2, hs_fall, vs_fall, hs_rise;
    rgb565_t    pix_q, pix_q2, first_pix;
    logic [10:0] h_cnt, hs_low;
    logic [9:0]  v_cnt;
    logic        hs_low_vld, phase, active, word_done, push, drop, frame_start;
    logic        fifo_full, fifo_empty;
    cap_state_t  state, state_nxt;

    assign hs_fall = hs_q2 && !hs_q;
    assign vs_fall = vs_q2 && !vs_q;
    assign hs_rise = !hs_q2 && hs_q;

    // second register stage on pixels lines them up with h_cnt/v_cnt
    always_ff @(posedge vga_clk) begin
        if (rst) begin
            hs_q   <= 1'b0;
            hs_q2  <= 1'b0;
            vs_q   <= 1'b0;
            vs_q2  <= 1'b0;
            pix_q  <= '0;
            pix_q2 <= '0;
        end else begin
            hs_q   <= vga_hsync;
            hs_q2  <= hs_q;
            vs_q   <= vga_vsync;
            vs_q2  <= vs_q;
            pix_q  <= {vga_r, vga_g, vga_b};
            pix_q2 <= pix_q;
        end
    end

    always_ff @(posedge vga_clk) begin
        if (rst) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else begin
            if (hs_fall)            h_cnt <= '0;
            else if (h_cnt != '1)   h_cnt <= h_cnt + 11'd1;
            if (vs_fall)                     v_cnt <= '0;
            else if (hs_fall && v_cnt != '1) v_cnt <= v_cnt + 10'd1;
        end
    end

    assign active    = (h_cnt >= H_LO) && (h_cnt < H_HI) && (v_cnt >= V_LO) && (v_cnt < V_HI);
    assign word_done = (state == CAPTURE) && active && phase;
    assign push      = word_done && !fifo_full;
    assign drop      = word_done && fifo_full;

    always_ff @(posedge vga_clk) begin
        if (rst) begin
            phase     <= 1'b0;
            first_pix <= '0;
        end else if (hs_fall || vs_fall) begin
            phase <= 1'b0;
        end else if (state == CAPTURE && active) begin
            phase <= !phase;
            if (!phase) first_pix <= pix_q2;
        end
    end

    always_ff @(posedge vga_clk) begin
        if (rst) state <= WAIT_INIT;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        frame_start = 1'b0;
        if (!ddr_init_done) begin
            state_nxt = WAIT_INIT;
        end else if (state == WAIT_INIT) begin
            state_nxt = WAIT_VSYNC;
        end else if (vs_fall) begin
            state_nxt   = CAPTURE;
            frame_start = 1'b1;
        end else if (state == CAPTURE && drop) begin
            state_nxt = DROP;
        end
    end

    assign vga_frame_sync = frame_start;

    // a drop in the last cycle of a frame still belongs to the frame being closed
    always_ff @(posedge vga_clk) begin
        if (rst)              cap_overflow <= 1'b0;
        else if (frame_start) cap_overflow <= 1'b0;
        else if (drop)        cap_overflow <= 1'b1;
    end

    vga_cap_fifo #(
        .WIDTH (32),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (vga_clk),
        .rst   (rst),
        .push  (push),
        .din   ({first_pix, pix_q2}),
        .pop   (ddr_wr_ready),
        .dout  (ddr_wr_data),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign ddr_wren = !fifo_empty;

`ifdef VGA_CAP_STATS_EN
    logic [15:0] frame_q, drop_q;
    always_ff @(posedge vga_clk) begin
        if (rst) begin
            frame_q <= '0;
            drop_q  <= '0;
        end else begin
            frame_q <= frame_q + 16'(frame_start);
            drop_q  <= drop_q + 16'(drop);
        end
    end
    assign frame_cnt = frame_q;
    assign drop_cnt  = drop_q;
`else
    assign frame_cnt = '0;
    assign drop_cnt  = '0;
`endif

    // sync checker: measured hsync low width must match H_SYNC_PULSE
    always_ff @(posedge vga_clk) begin
        if (rst) begin
            hs_low     <= '0;
            hs_low_vld <= 1'b0;
        end else if (hs_fall) begin
            hs_low     <= 11'd1;
            hs_low_vld <= 1'b1;
        end else if (!hs_q && hs_low != '1) begin
            hs_low <= hs_low + 11'd1;
        end
    end

    hsync_width_chk: assert property (@(posedge vga_clk) disable iff (rst)
        (hs_rise && hs_low_vld) |-> (hs_low == H_SYNC_W));

endmodule

// File: tb/tb_vga_capture.sv
// Directed bench for vga_capture on a scaled-down 24x10 raster (8x6 active) so every
// frame-level scenario fits in a short run.
module tb_vga_capture;
    import vga_pkg::*;

    localparam int H_SYNC = 4;
    localparam int HDE    = 10;
    localparam int H_ACT  = 8;
    localparam int H_TOT  = 24;
    localparam int VDE    = 3;
    localparam int V_ACT  = 6;
    localparam int V_SYNC = 2;
    localparam int V_TOT  = 10;
    localparam int FRAME  = H_TOT * V_TOT;
    localparam int WORDS  = H_ACT * V_ACT / 2;
`ifdef VGA_CAP_STATS_EN
    localparam logic [31:0] STAT_MASK = 32'hFFFF_FFFF;
`else
    localparam logic [31:0] STAT_MASK = 32'h0;
`endif

    logic        vga_clk = 1'b0;
    logic        rst, ddr_init_done, vga_hsync, vga_vsync, ddr_wr_ready;
    logic [4:0]  vga_r, vga_b;
    logic [5:0]  vga_g;
    logic [31:0] ddr_wr_data;
    logic        ddr_wren, vga_frame_sync, cap_overflow;
    logic [15:0] frame_cnt, drop_cnt;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          wren_cyc = 0;
    int          fs_cnt = 0;
    int          xfer_cnt = 0;
    int          first_xfer_cyc = -1;
    int          t_pix1 = -1;
    logic [31:0] xfer_dat [512];
    int          b_x, b_w, b_f;

    vga_capture #(
        .H_SYNC_PULSE (H_SYNC),
        .HDE_START    (HDE),
        .H_ACTIVE     (H_ACT),
        .VDE_START    (VDE),
        .V_ACTIVE     (V_ACT),
        .FIFO_DEPTH   (4)
    ) dut (
        .vga_clk        (vga_clk),
        .rst            (rst),
        .ddr_init_done  (ddr_init_done),
        .vga_hsync      (vga_hsync),
        .vga_vsync      (vga_vsync),
        .vga_r          (vga_r),
        .vga_g          (vga_g),
        .vga_b          (vga_b),
        .ddr_wr_data    (ddr_wr_data),
        .ddr_wren       (ddr_wren),
        .ddr_wr_ready   (ddr_wr_ready),
        .vga_frame_sync (vga_frame_sync),
        .cap_overflow   (cap_overflow),
        .frame_cnt      (frame_cnt),
        .drop_cnt       (drop_cnt)
    );

    always #5 vga_clk = !vga_clk;

    always @(posedge vga_clk) cyc++;

    always @(negedge vga_clk) begin
        if (ddr_wren) wren_cyc++;
        if (vga_frame_sync) fs_cnt++;
        if (ddr_wren && ddr_wr_ready) begin
            if (xfer_cnt == 0) first_xfer_cyc = cyc;
            if (xfer_cnt < 512) xfer_dat[xfer_cnt] = ddr_wr_data;
            xfer_cnt++;
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge vga_clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            vga_hsync = 1'b1;
            vga_vsync = 1'b1;
            {vga_r, vga_g, vga_b} = 16'h0;
            step();
        end
    endtask

    // drives raster positions [first, last); active pixel value = its index within the frame
    task automatic drive_range(input int first, input int last);
        for (int p = first; p < last; p++) begin
            int x, y;
            logic [15:0] pix;
            x = p % H_TOT;
            y = p / H_TOT;
            vga_hsync = (x >= H_SYNC);
            vga_vsync = (y >= V_SYNC);
            if (x >= HDE && x < HDE + H_ACT && y >= VDE && y < VDE + V_ACT) begin
                pix = 16'((y - VDE) * H_ACT + (x - HDE));
                if (pix == 16'd1) t_pix1 = cyc;
            end else begin
                pix = 16'hDEAD;
            end
            {vga_r, vga_g, vga_b} = pix;
            step();
        end
    endtask

    task automatic take_base();
        b_x = xfer_cnt;
        b_w = wren_cyc;
        b_f = fs_cnt;
    endtask

    initial begin
        int cut;
        rst = 1'b1;
        ddr_init_done = 1'b0;
        ddr_wr_ready = 1'b1;
        vga_hsync = 1'b1;
        vga_vsync = 1'b1;
        {vga_r, vga_g, vga_b} = 16'h0;
        step();
        step();
        check_val("rst_wren", 32'(ddr_wren), 32'd0);
        check_val("rst_data", ddr_wr_data, 32'd0);
        check_val("rst_fsync", 32'(vga_frame_sync), 32'd0);
        check_val("rst_ovf", 32'(cap_overflow), 32'd0);
        check_val("rst_frame_cnt", 32'(frame_cnt), 32'd0);
        check_val("rst_drop_cnt", 32'(drop_cnt), 32'd0);
        check_val("rst_state", 32'(dut.state), 32'(WAIT_INIT));
        rst = 1'b0;

        // DDR not ready: a full frame plus the next vsync edge must produce nothing
        take_base();
        drive_range(0, FRAME);
        drive_range(0, 3 * H_TOT);
        idle(4);
        check_val("noinit_wren", 32'(wren_cyc - b_w), 32'd0);
        check_val("noinit_fsync", 32'(fs_cnt - b_f), 32'd0);
        check_val("noinit_state", 32'(dut.state), 32'(WAIT_INIT));
        ddr_init_done = 1'b1;
        idle(2);
        check_val("init_state", 32'(dut.state), 32'(WAIT_VSYNC));

        // full frame, sink always ready
        take_base();
        drive_range(0, FRAME);
        idle(8);
        check_val("full_xfers", 32'(xfer_cnt - b_x), 32'(WORDS));
        check_val("full_word0", xfer_dat[b_x], 32'h0000_0001);
        check_val("full_word1", xfer_dat[b_x + 1], 32'h0002_0003);
        check_val("full_wordN", xfer_dat[b_x + WORDS - 1], 32'h002E_002F);
        check_val("full_latency", 32'(first_xfer_cyc - t_pix1), 32'd3);
        check_val("full_ovf", 32'(cap_overflow), 32'd0);
        check_val("full_fsync", 32'(fs_cnt - b_f), 32'd1);
        check_val("full_frame_cnt", 32'(frame_cnt), 32'd1 & STAT_MASK);

        // sink stalled from frame start: 4 words held, 5th dropped, rest of frame skipped
        ddr_wr_ready = 1'b0;
        take_base();
        drive_range(0, FRAME);
        idle(4);
        check_val("ovf_count", 32'(dut.u_fifo.count), 32'd4);
        check_val("ovf_flag", 32'(cap_overflow), 32'd1);
        check_val("ovf_drop_cnt", 32'(drop_cnt), 32'd1 & STAT_MASK);
        check_val("ovf_state", 32'(dut.state), 32'(DROP));
        check_val("ovf_head", ddr_wr_data, 32'h0000_0001);
        check_val("ovf_wren", 32'(ddr_wren), 32'd1);
        ddr_wr_ready = 1'b1;
        idle(8);
        check_val("ovf_drain", 32'(xfer_cnt - b_x), 32'd4);
        check_val("ovf_drain_w0", xfer_dat[b_x], 32'h0000_0001);
        check_val("ovf_drain_w3", xfer_dat[b_x + 3], 32'h0006_0007);
        take_base();
        drive_range(0, H_TOT);
        check_val("ovf_clear", 32'(cap_overflow), 32'd0);
        check_val("ovf_recap_state", 32'(dut.state), 32'(CAPTURE));
        drive_range(H_TOT, FRAME);
        idle(8);
        check_val("ovf_recap_xfers", 32'(xfer_cnt - b_x), 32'(WORDS));

        // mid-line reset inside the active area
        cut = (VDE + 1) * H_TOT + HDE + 3;
        drive_range(0, cut);
        rst = 1'b1;
        drive_range(cut, cut + 1);
        rst = 1'b0;
        check_val("mrst_wren", 32'(ddr_wren), 32'd0);
        check_val("mrst_count", 32'(dut.u_fifo.count), 32'd0);
        check_val("mrst_state", 32'(dut.state), 32'(WAIT_INIT));
        check_val("mrst_frame_cnt", 32'(frame_cnt), 32'd0);
        take_base();
        drive_range(cut + 1, FRAME);
        idle(4);
        check_val("mrst_no_xfer", 32'(xfer_cnt - b_x), 32'd0);
        take_base();
        drive_range(0, FRAME);
        idle(8);
        check_val("mrst_resume_xfers", 32'(xfer_cnt - b_x), 32'(WORDS));
        check_val("mrst_resume_w0", xfer_dat[b_x], 32'h0000_0001);
        check_val("mrst_frame_cnt1", 32'(frame_cnt), 32'd1 & STAT_MASK);

        // vsync falls after three active pixels: half pair is discarded
        take_base();
        drive_range(0, VDE * H_TOT + HDE + 3);
        check_val("odd_frame_cnt_pre", 32'(frame_cnt), 32'd2 & STAT_MASK);
        drive_range(0, FRAME);
        idle(8);
        check_val("odd_xfers", 32'(xfer_cnt - b_x), 32'(WORDS + 1));
        check_val("odd_old_w0", xfer_dat[b_x], 32'h0000_0001);
        check_val("odd_new_w0", xfer_dat[b_x + 1], 32'h0000_0001);
        check_val("odd_new_w1", xfer_dat[b_x + 2], 32'h0002_0003);
        check_val("odd_frame_cnt", 32'(frame_cnt), 32'd3 & STAT_MASK);
        check_val("odd_fsync", 32'(fs_cnt - b_f), 32'd2);
        check_val("odd_drop_cnt", 32'(drop_cnt), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
